spikes_trap_matrix: RTL and testbench

Parametrised, animated successor to the static spike-tile overlay. It holds a per-tile spike mask for the playfield, selected from NUM_LAYOUTS preset layouts while the game is idle. A frame-driven phase FSM cycles the spikes through retract, rise, armed and fall phases. It renders the per-pixel RGB with one cycle of latency, flags lethal pixels for the collision logic, and lets explosions destroy individual spike tiles at run time.

---
 rtl/spikes_trap_matrix.sv | 162 ++++++++++++++++
 tb/tb_spikes_trap_matrix.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spikes_trap_matrix.sv
// spikes_trap_matrix: animated per-tile spike overlay with layouts and a phase FSM.
// Optional define SPIKES_PHASE_STAGGER_EN: odd-parity tiles run two phases ahead.
module spikes_trap_matrix #(
    parameter int TILE_BITS      = 5,
    parameter int MAZE_COLS      = 19,
    parameter int MAZE_ROWS      = 13,
    parameter int COL_BITS       = 5,
    parameter int ROW_BITS       = 4,
    parameter int NUM_LAYOUTS    = 5,
    parameter int DEFAULT_LAYOUT = 0,
    parameter int IDLE_FRAMES    = 90,
    parameter int MOVE_FRAMES    = 8,
    parameter int ARMED_FRAMES   = 60
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                startOfFrame,
    input  logic [10:0]         offsetX,
    input  logic [10:0]         offsetY,
    input  logic                InsideRectangle,
    input  logic                game_on,
    input  logic [3:0]          layout_sel,
    input  logic                clear_valid,
    input  logic [COL_BITS-1:0] clear_col,
    input  logic [ROW_BITS-1:0] clear_row,
    output logic                drawingRequest,
    output logic [7:0]          RGBout,
    output logic                spikeLethal,
    output logic [1:0]          phase
);

    typedef enum logic [1:0] {
        RETRACTED = 2'd0,
        RISING    = 2'd1,
        ARMED     = 2'd2,
        FALLING   = 2'd3
    } phase_e;

    localparam int CNT_W = 8;

    // Layout k: tile present when ((col ^ row) + k) is not a multiple of 3.
    function automatic logic layout_bit(input logic [3:0] k, input int r, input int c);
        int s;
        s = (c ^ r) + int'(k);
        return (s % 3) != 0;
    endfunction

    // Four 8-pixel-wide spikes per tile, widening downwards, outlined, solid base row.
    function automatic logic [7:0] sprite(input logic [TILE_BITS-1:0] lx,
                                          input logic [TILE_BITS-1:0] ly);
        logic [3:0]           d;
        logic [TILE_BITS-1:0] half;
        d    = lx[2] ? ({lx[2:0], 1'b0} - 4'd7) : (4'd7 - {lx[2:0], 1'b0});
        half = ly >> 1;
        if (32'(d) > 32'(half))
            return 8'hFF;
        else if (32'(d) == 32'(half) || (&ly))
            return 8'h00;
        else
            return 8'hB6;
    endfunction

    function automatic logic [CNT_W-1:0] dur_last(input phase_e p);
        int d;
        unique case (p)
            RETRACTED: d = IDLE_FRAMES;
            ARMED:     d = ARMED_FRAMES;
            default:   d = MOVE_FRAMES;
        endcase
        return CNT_W'(d - 1);
    endfunction

    logic [MAZE_ROWS-1:0][MAZE_COLS-1:0] mask_q;
    phase_e                              phase_q;
    logic [CNT_W-1:0]                    cnt_q;
    logic [7:0]                          rgb_q;
    logic                                lethal_q;

    logic [COL_BITS-1:0]  col;
    logic [ROW_BITS-1:0]  row;
    logic [TILE_BITS-1:0] lx, ly;
    logic                 tile_in, clr_in, tile_bit, vis_d;
    phase_e               p_d;
    logic [7:0]           pix_d;
    logic                 unused_bits;

    assign col = offsetX[TILE_BITS+COL_BITS-1:TILE_BITS];
    assign row = offsetY[TILE_BITS+ROW_BITS-1:TILE_BITS];
    assign lx  = offsetX[TILE_BITS-1:0];
    assign ly  = offsetY[TILE_BITS-1:0];
    assign unused_bits = ^{offsetX[10:TILE_BITS+COL_BITS], offsetY[10:TILE_BITS+ROW_BITS]};

    assign tile_in = (32'(col) < MAZE_COLS) && (32'(row) < MAZE_ROWS);
    assign clr_in  = (32'(clear_col) < MAZE_COLS) && (32'(clear_row) < MAZE_ROWS);

    // Mask: layout reload while idle has priority over explosion clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < MAZE_ROWS; r++)
                for (int c = 0; c < MAZE_COLS; c++)
                    mask_q[r][c] <= layout_bit(4'(DEFAULT_LAYOUT), r, c);
        end else if (!game_on) begin
            if (32'(layout_sel) < NUM_LAYOUTS)
                for (int r = 0; r < MAZE_ROWS; r++)
                    for (int c = 0; c < MAZE_COLS; c++)
                        mask_q[r][c] <= layout_bit(layout_sel, r, c);
        end else if (clear_valid && clr_in) begin
            mask_q[clear_row][clear_col] <= 1'b0;
        end
    end

    // Phase FSM: frame-counted dwell in each phase, held retracted while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= RETRACTED;
            cnt_q   <= '0;
        end else if (!game_on) begin
            phase_q <= RETRACTED;
            cnt_q   <= '0;
        end else if (startOfFrame) begin
            if (cnt_q == dur_last(phase_q)) begin
                cnt_q   <= '0;
                phase_q <= phase_e'(phase_q + 2'd1);
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Tile phase, visibility and sprite lookup for the current pixel.
    always_comb begin
        tile_bit = 1'b0;
        if (tile_in)
            tile_bit = mask_q[row][col];
`ifdef SPIKES_PHASE_STAGGER_EN
        p_d = (row[0] ^ col[0]) ? phase_e'(phase_q + 2'd2) : phase_q;
`else
        p_d = phase_q;
`endif
        pix_d = sprite(lx, ly);
        vis_d = InsideRectangle && tile_bit &&
                ((p_d == ARMED) ||
                 ((p_d == RISING || p_d == FALLING) && ly[TILE_BITS-1]));
    end

    // Render register: one clock of latency from pixel coordinates to colour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q    <= 8'hFF;
            lethal_q <= 1'b0;
        end else begin
            rgb_q    <= vis_d ? pix_d : 8'hFF;
            lethal_q <= vis_d && (p_d == ARMED) && (pix_d != 8'hFF);
        end
    end

    assign RGBout         = rgb_q;
    assign drawingRequest = (rgb_q != 8'hFF);
    assign spikeLethal    = lethal_q;
    assign phase          = phase_q;

endmodule

// File: tb/tb_spikes_trap_matrix.sv
// tb_spikes_trap_matrix: directed and random checks against a frame/tile model.
// Stagger expectations follow SPIKES_PHASE_STAGGER_EN when defined.
module tb_spikes_trap_matrix;

    logic        clk = 0;
    logic        reset;
    logic        startOfFrame;
    logic [10:0] offsetX, offsetY;
    logic        InsideRectangle;
    logic        game_on;
    logic [3:0]  layout_sel;
    logic        clear_valid;
    logic [4:0]  clear_col;
    logic [3:0]  clear_row;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic        spikeLethal;
    logic [1:0]  phase;

    int checks = 0;
    int errors = 0;

    spikes_trap_matrix #(
        .IDLE_FRAMES(2), .MOVE_FRAMES(1), .ARMED_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
        .game_on(game_on), .layout_sel(layout_sel), .clear_valid(clear_valid),
        .clear_col(clear_col), .clear_row(clear_row),
        .drawingRequest(drawingRequest), .RGBout(RGBout),
        .spikeLethal(spikeLethal), .phase(phase)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit m[13][19];
    int ph, cnt;
    int dur[4] = '{2, 1, 2, 1};

    function automatic bit lay(int k, int r, int c);
        return (((c ^ r) + k) % 3) != 0;
    endfunction

    function automatic int spr(int lx, int ly);
        int d;
        d = 2 * (lx % 8) - 7;
        if (d < 0) d = -d;
        if (d > ly / 2) return 'hFF;
        if (d == ly / 2 || ly == 31) return 'h00;
        return 'hB6;
    endfunction

    task automatic load(int k);
        for (int r = 0; r < 13; r++)
            for (int c = 0; c < 19; c++)
                m[r][c] = lay(k, r, c);
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        int c, r, lx, ly, p, er, el;
        bit vis;
        c  = (int'(offsetX) / 32) % 32;
        r  = (int'(offsetY) / 32) % 16;
        lx = int'(offsetX) % 32;
        ly = int'(offsetY) % 32;
        p  = ph;
`ifdef SPIKES_PHASE_STAGGER_EN
        if ((r + c) % 2 == 1) p = (ph + 2) % 4;
`endif
        vis = InsideRectangle && c < 19 && r < 13 && m[r % 13][c % 19] &&
              (p == 2 || ((p == 1 || p == 3) && ly >= 16));
        er = vis ? spr(lx, ly) : 'hFF;
        el = (vis && p == 2 && er != 'hFF) ? 1 : 0;
        @(posedge clk);
        if (!game_on) begin
            if (layout_sel < 5) load(int'(layout_sel));
            ph = 0;
            cnt = 0;
        end else begin
            if (clear_valid && clear_col < 19 && clear_row < 13)
                m[clear_row][clear_col] = 0;
            if (startOfFrame) begin
                if (cnt == dur[ph] - 1) begin
                    cnt = 0;
                    ph = (ph + 1) % 4;
                end else begin
                    cnt++;
                end
            end
        end
        #1;
        chk("rgb", 32'(RGBout), 32'(er));
        chk("dreq", 32'(drawingRequest), 32'(er != 'hFF));
        chk("lethal", 32'(spikeLethal), 32'(el));
        chk("phase", 32'(phase), 32'(ph));
    endtask

    task automatic pulse(int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1;
            cycle();
            startOfFrame = 0;
            cycle();
        end
    endtask

    task automatic pix(int x, int y);
        offsetX = 11'(x);
        offsetY = 11'(y);
        InsideRectangle = 1;
        cycle();
    endtask

    task automatic idle(int k);
        game_on = 0;
        layout_sel = 4'(k);
        cycle();
        game_on = 1;
        layout_sel = 0;
    endtask

    int seq[7] = '{0, 1, 2, 2, 3, 0, 0};

    initial begin
        reset = 1;
        startOfFrame = 0;
        offsetX = 0;
        offsetY = 0;
        InsideRectangle = 0;
        game_on = 0;
        layout_sel = 0;
        clear_valid = 0;
        clear_col = 0;
        clear_row = 0;
        load(0);
        ph = 0;
        cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rgb", 32'(RGBout), 32'hFF);
        chk("rst_phase", 32'(phase), 0);
        reset = 0;

        // Layout 1 load, then phase walk over 7 frames
        idle(1);
        for (int i = 0; i < 7; i++) begin
            pulse(1);
            chk("seq", 32'(phase), 32'(seq[i]));
        end

        // Layout 0, ARMED body pixel
        idle(0);
        pulse(3);
        chk("armed", 32'(phase), 2);
        pix(9 * 32 + 4, 4 * 32 + 7);
        chk("body_rgb", 32'(RGBout), 32'hB6);
        chk("body_dreq", 32'(drawingRequest), 1);
        chk("body_leth", 32'(spikeLethal), 1);

        // Asynchronous reset while ARMED and game_on=1
        @(negedge clk);
        reset = 1;
        #2;
        chk("arst_phase", 32'(phase), 0);
        chk("arst_rgb", 32'(RGBout), 32'hFF);
        chk("arst_dreq", 32'(drawingRequest), 0);
        chk("arst_leth", 32'(spikeLethal), 0);
        load(0);
        ph = 0;
        cnt = 0;
        @(negedge clk);
        reset = 0;

        // RISING: lower half only, reset mask is layout 0
        pulse(2);
        chk("rising", 32'(phase), 1);
        pix(9 * 32 + 4, 4 * 32 + 7);
        chk("rise_top", 32'(RGBout), 32'hFF);
        pix(9 * 32 + 4, 4 * 32 + 20);
        chk("rise_low", 32'(RGBout), 32'hB6);
        chk("rise_leth", 32'(spikeLethal), 0);

        // Clear during ARMED
        pulse(1);
        chk("armed2", 32'(phase), 2);
        clear_valid = 1;
        clear_col = 9;
        clear_row = 4;
        cycle();
        clear_valid = 0;
        pix(9 * 32 + 4, 4 * 32 + 7);
        chk("cleared", 32'(RGBout), 32'hFF);

        // Invalid layout index keeps the mask
        idle(9);
        pulse(3);
        pix(9 * 32 + 4, 4 * 32 + 7);
        chk("sel9_clr", 32'(RGBout), 32'hFF);
        pix(2 * 32 + 4, 0 * 32 + 7);
        chk("sel9_keep", 32'(RGBout), 32'hB6);

        // Stagger: RETRACTED globally, odd vs even parity tile
        idle(0);
        pix(1 * 32 + 4, 10 * 32 + 7);
`ifdef SPIKES_PHASE_STAGGER_EN
        chk("stag_odd", 32'(RGBout), 32'hB6);
        chk("stag_leth", 32'(spikeLethal), 1);
`else
        chk("stag_odd", 32'(RGBout), 32'hFF);
        chk("stag_leth", 32'(spikeLethal), 0);
`endif
        pix(2 * 32 + 4, 0 * 32 + 7);
        chk("stag_even", 32'(RGBout), 32'hFF);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            game_on = ($urandom % 60) != 0;
            layout_sel = 4'($urandom % 8);
            startOfFrame = ($urandom % 3) == 0;
            offsetX = 11'($urandom % 800);
            offsetY = 11'($urandom % 600);
            InsideRectangle = ($urandom % 10) != 0;
            clear_valid = ($urandom % 25) == 0;
            clear_col = 5'($urandom);
            clear_row = 4'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
